// File: rtl/rx_block_assembler.sv
// rx_block_assembler: collects UART bytes into a 128-bit TEA key ('K' + 16
// bytes) or a 64-bit data block ('D' + 8 bytes) and hands the block to the
// TEA core with a valid/ready handshake.
// Optional build macro RX_TIMEOUT_EN: abandons a KEY/DATA frame after
// TIMEOUT_CYCLES cycles without a byte and reports it on err.
module rx_block_assembler #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_valid,
   input  logic [7:0]   rx_byte,
   output logic [127:0] key,
   output logic         key_valid,
   output logic [63:0]  blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         err,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, KEY, DATA, HOLD} state_t;

   localparam logic [7:0] CMD_KEY  = 8'h4B;
   localparam logic [7:0] CMD_DATA = 8'h44;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [127:0]   shadow_q, shadow_d;
   logic [127:0]   key_q, key_d;
   logic           key_valid_q, key_valid_d;
   logic [63:0]    blk_data_q, blk_data_d;
   logic           blk_valid_q, blk_valid_d;
   logic           err_q, err_d;

`ifdef RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]  idle_cnt_q, idle_cnt_d;
`endif

   // Next-state and next-output computation for the whole assembler
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      blk_data_d  = blk_data_q;
      blk_valid_d = blk_valid_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 4'd0;
            if (rx_valid) begin
               if (rx_byte == CMD_KEY) begin
                  state_d = KEY;
               end else if (rx_byte == CMD_DATA && key_valid_q) begin
                  state_d = DATA;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         KEY: begin
            if (rx_valid) begin
               shadow_d = {shadow_q[119:0], rx_byte};
               cnt_d    = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  // key is only ever written here, so a partial frame never leaks out
                  key_d       = {shadow_q[119:0], rx_byte};
                  key_valid_d = 1'b1;
                  state_d     = IDLE;
                  cnt_d       = 4'd0;
               end
            end
         end
         DATA: begin
            if (rx_valid) begin
               blk_data_d = {blk_data_q[55:0], rx_byte};
               cnt_d      = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  state_d     = HOLD;
                  blk_valid_d = 1'b1;
                  cnt_d       = 4'd0;
               end
            end
         end
         HOLD: begin
            // bytes arriving while a block is pending are dropped and flagged
            if (rx_valid) begin
               err_d = 1'b1;
            end
            if (blk_ready) begin
               blk_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef RX_TIMEOUT_EN
      // idle counter runs only inside a frame and restarts on each byte
      idle_cnt_d = '0;
      if ((state_q == KEY || state_q == DATA) && !rx_valid) begin
         if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            err_d   = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
`endif
   end

   // State and registered outputs, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         shadow_q    <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         blk_data_q  <= '0;
         blk_valid_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef RX_TIMEOUT_EN
         idle_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         blk_data_q  <= blk_data_d;
         blk_valid_q <= blk_valid_d;
         err_q       <= err_d;
`ifdef RX_TIMEOUT_EN
         idle_cnt_q  <= idle_cnt_d;
`endif
      end
   end

   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign blk_data  = blk_data_q;
   assign blk_valid = blk_valid_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rx_block_assembler.sv
// Testbench for rx_block_assembler: fixed vector table, directed frame
// sequences and random frames against a byte-queue reference model.
module tb_rx_block_assembler;

`ifdef RX_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         rx_valid;
   logic [7:0]   rx_byte;
   logic [127:0] key;
   logic         key_valid;
   logic [63:0]  blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic         err;
   logic         busy;

   rx_block_assembler #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .key       (key),
      .key_valid (key_valid),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: mode 0 idle, 1 collecting key, 2 collecting block, 3 block pending
   int           m_mode;
   logic [7:0]   m_q[$];
   logic [127:0] m_key;
   logic         m_kv;
   logic [63:0]  m_blk;
   logic         m_bv;
   logic         m_err;
   bit           m_blk_unk;
   int           m_idle;

   function automatic void model_reset();
      m_mode = 0; m_q.delete(); m_key = '0; m_kv = 0; m_blk = '0; m_bv = 0;
      m_err = 0; m_blk_unk = 0; m_idle = 0;
   endfunction

   function automatic void model_step(logic v, logic [7:0] b, logic rdy);
      int pm;
      pm = m_mode;
      m_err = 0;
      case (m_mode)
         0: if (v) begin
               if (b == 8'h4B) begin
                  m_mode = 1; m_q.delete(); m_idle = 0;
               end else if (b == 8'h44 && m_kv) begin
                  m_mode = 2; m_q.delete(); m_idle = 0; m_blk_unk = 1;
               end else m_err = 1;
            end
         1: if (v) begin
               m_q.push_back(b);
               if (m_q.size() == 16) begin
                  for (int i = 0; i < 16; i++) m_key[127-8*i -: 8] = m_q[i];
                  m_kv = 1; m_mode = 0;
               end
            end
         2: if (v) begin
               m_q.push_back(b);
               if (m_q.size() == 8) begin
                  for (int i = 0; i < 8; i++) m_blk[63-8*i -: 8] = m_q[i];
                  m_bv = 1; m_mode = 3; m_blk_unk = 0;
               end
            end
         default: begin
               if (v) m_err = 1;
               if (rdy) begin m_bv = 0; m_mode = 0; end
            end
      endcase
`ifdef RX_TIMEOUT_EN
      if ((pm == 1 || pm == 2) && !v) begin
         m_idle++;
         if (m_idle == TO) begin m_mode = 0; m_err = 1; m_idle = 0; end
      end else m_idle = 0;
`else
      if (pm < 0) m_idle = 0;
`endif
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("key", key, m_key);
      check("key_valid", 128'(key_valid), 128'(m_kv));
      check("blk_valid", 128'(blk_valid), 128'(m_bv));
      check("err", 128'(err), 128'(m_err));
      check("busy", 128'(busy), 128'(m_mode != 0));
      if (!m_blk_unk) check("blk_data", 128'(blk_data), 128'(m_blk));
   endtask

   // Called at a negedge: drive, let one rising edge pass, compare at next negedge
   task automatic step(logic v, logic [7:0] b, logic rdy);
      rx_valid = v; rx_byte = b; blk_ready = rdy;
      model_step(v, b, rdy);
      @(negedge clk);
      compare_all();
   endtask

   task automatic reset_now();
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic       v;
      logic [7:0] b;
      logic       rdy;
      logic       e_err;
      logic       e_busy;
      logic       e_bv;
   } vec_t;

   vec_t tbl[10];

   initial begin
      rx_valid = 0; rx_byte = 0; blk_ready = 0;
      model_reset();
      // 'D' without key, then eight bytes: every byte in IDLE is an error
      tbl[0] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 1; i <= 8; i++) tbl[i] = '{1'b1, 8'(i * 8'h11), 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].b, tbl[i].rdy);
         check("tbl_err", 128'(err), 128'(tbl[i].e_err));
         check("tbl_busy", 128'(busy), 128'(tbl[i].e_busy));
         check("tbl_bv", 128'(blk_valid), 128'(tbl[i].e_bv));
         $display("vector %0d: v=%0b byte=%h err=%0b busy=%0b", i, tbl[i].v, tbl[i].b, err, busy);
      end

      // Key load 'K' + 00..0F
      step(1, 8'h4B, 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("key_before_commit", 128'(key_valid), 128'd0);
         step(1, 8'(i), 0);
      end
      check("key_const", key, 128'h000102030405060708090A0B0C0D0E0F);
      check("key_valid_const", 128'(key_valid), 128'd1);
      $display("key loaded: %h", key);

      // Data block held with ready low, stray byte in HOLD, then handshake
      step(1, 8'h44, 0);
      for (int i = 1; i <= 8; i++) step(1, 8'(i * 8'h11), 0);
      repeat (20) step(0, 8'h00, 0);
      check("blk_held", 128'(blk_data), 128'h1122334455667788);
      check("blk_valid_held", 128'(blk_valid), 128'd1);
      step(1, 8'h55, 0);
      check("hold_err", 128'(err), 128'd1);
      check("hold_blk", 128'(blk_data), 128'h1122334455667788);
      step(0, 8'h00, 1);
      check("handshake_drop", 128'(blk_valid), 128'd0);
      check("handshake_idle", 128'(busy), 128'd0);
      step(0, 8'h00, 0);
      $display("block handshake done: %h", blk_data);

      // Handshake with simultaneous stray byte
      step(1, 8'h44, 0);
      for (int i = 0; i < 8; i++) step(1, 8'(8'hA0 + i), 0);
      step(1, 8'h33, 1);
      check("hs_byte_err", 128'(err), 128'd1);
      check("hs_byte_blk", 128'(blk_data), 128'hA0A1A2A3A4A5A6A7);
      step(0, 8'h00, 0);

`ifdef RX_TIMEOUT_EN
      // Partial key frame abandoned by timeout; committed key is kept
      step(1, 8'h4B, 0);
      for (int i = 0; i < 3; i++) step(1, 8'hF0, 0);
      for (int i = 0; i < TO; i++) step(0, 8'h00, 0);
      check("timeout_err", 128'(err), 128'd1);
      check("timeout_idle", 128'(busy), 128'd0);
      check("timeout_key", key, 128'h000102030405060708090A0B0C0D0E0F);
      step(0, 8'h00, 0);
      $display("timeout frame done");
`endif

      // Illegal byte, partial key, then reset mid-frame
      step(1, 8'h7A, 0);
      check("bad_byte_err", 128'(err), 128'd1);
      step(1, 8'h4B, 0);
      for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0);
      reset_now();
      check("rst_key", key, 128'd0);
      check("rst_kv", 128'(key_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      step(0, 8'h00, 0);
      check("rst_no_err", 128'(err), 128'd0);
      $display("mid-frame reset done");

      // Random frames
      for (int f = 0; f < 150; f++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind <= 3) begin
            step(1, 8'h4B, 0);
            for (int i = 0; i < 16; i++) begin
               repeat ($urandom_range(0, 2)) step(0, 8'h00, 1'($urandom));
               step(1, 8'($urandom), 1'($urandom));
            end
         end else if (kind <= 7) begin
            step(1, 8'h44, 0);
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 2)) step(0, 8'h00, 1'($urandom));
               step(1, 8'($urandom), 0);
            end
            for (int c = 0; c < 40 && m_mode == 3; c++)
               step(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) == 0) || c == 39);
         end else if (kind == 8) begin
            step(1, 8'($urandom), 1'($urandom));
         end else begin
            repeat ($urandom_range(1, 6)) step(1, 8'($urandom), 0);
            reset_now();
         end
         step(0, 8'h00, 0);
         $display("frame %0d kind %0d key_valid=%0b blk_valid=%0b", f, kind, key_valid, blk_valid);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
